fpu_add_scheduler: RTL and testbench

FPU_ADD_SCHEDULER -- requirements
Module: fpu_add_scheduler

---
 rtl/fpu_pkg.sv | 16 +
 rtl/fxp_add.sv | 34 +++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/fpu_add_scheduler.sv | 112 +++++++++++
 tb/tb_fpu_add_scheduler.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the fixed-point add scheduler.
// Operands are sign-magnitude Q16.15: sign bit 31, integer bits 30:15, fraction bits 14:0.
package fpu_pkg;

    localparam int unsigned FRAC_BITS = 15;
    localparam int unsigned SIGN_BIT  = 31;

    typedef logic [31:0] fixed_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/fxp_add.sv
// Combinational sign-magnitude Q16.15 adder; magnitude wraps on overflow, zero is always positive.
module fxp_add
    import fpu_pkg::*;
(
    input  fixed_t a,
    input  fixed_t b,
    output fixed_t sum_c
);

    logic [SIGN_BIT-1:0] mag_a;
    logic [SIGN_BIT-1:0] mag_b;
    logic [SIGN_BIT-1:0] mag;
    logic                sign;

    always_comb begin
        mag_a = a[SIGN_BIT-1:0];
        mag_b = b[SIGN_BIT-1:0];
        mag   = '0;
        sign  = 1'b0;
        if (a[SIGN_BIT] == b[SIGN_BIT]) begin
            mag  = mag_a + mag_b;
            sign = a[SIGN_BIT];
        end else if (mag_a >= mag_b) begin
            mag  = mag_a - mag_b;
            sign = a[SIGN_BIT];
        end else begin
            mag  = mag_b - mag_a;
            sign = b[SIGN_BIT];
        end
        // Never produce negative zero.
        sum_c = {sign & (mag != '0), mag};
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves past the winner on advance.
module rr_arbiter #(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant_c,
    output logic [IDX_W-1:0] grant_id_c
);

    logic [IDX_W-1:0] ptr;

    // Scan from the pointer upward, wrapping, and take the first asserted request.
    always_comb begin
        int   idx;
        logic found;
        idx        = 0;
        found      = 1'b0;
        grant_c    = '0;
        grant_id_c = '0;
        for (int k = 0; k < int'(N); k++) begin
            idx = (int'(ptr) + k) % int'(N);
            if (!found && req[IDX_W'(idx)]) begin
                found                  = 1'b1;
                grant_c[IDX_W'(idx)]   = 1'b1;
                grant_id_c             = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_id_c == IDX_W'(N - 1)) ? '0 : grant_id_c + IDX_W'(1);
        end
    end

endmodule

// File: rtl/fpu_add_scheduler.sv
// Shares one fixed-point adder among NUM_REQ requesters: round-robin accept, one-cycle
// execute, then hold the result until the owning requester takes it.
module fpu_add_scheduler
    import fpu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic   [NUM_REQ-1:0]       req_valid,
    output logic   [NUM_REQ-1:0]       req_ready,
    input  fixed_t [NUM_REQ-1:0]       req_a,
    input  fixed_t [NUM_REQ-1:0]       req_b,
    output logic   [NUM_REQ-1:0]       rsp_valid,
    input  logic   [NUM_REQ-1:0]       rsp_ready,
    output fixed_t                     rsp_result,
    output logic                       busy,
    output logic   [CNT_W-1:0]         done_count
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    state_t             state, state_next;
    fixed_t             op_a, op_a_next;
    fixed_t             op_b, op_b_next;
    logic [IDX_W-1:0]   id, id_next;
    fixed_t             result_next;
    logic [CNT_W-1:0]   count_next;
    logic [NUM_REQ-1:0] rsp_valid_next;
    logic               accept;
    logic [NUM_REQ-1:0] grant_c;
    logic [IDX_W-1:0]   grant_id_c;
    fixed_t             sum_c;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req_valid),
        .advance    (accept),
        .grant_c    (grant_c),
        .grant_id_c (grant_id_c)
    );

    fxp_add u_add (
        .a     (op_a),
        .b     (op_b),
        .sum_c (sum_c)
    );

    always_comb begin
        state_next     = state;
        op_a_next      = op_a;
        op_b_next      = op_b;
        id_next        = id;
        result_next    = rsp_result;
        count_next     = done_count;
        accept         = 1'b0;
        req_ready      = '0;
        rsp_valid_next = '0;
        case (state)
            IDLE: begin
                req_ready = grant_c;
                if (|(req_valid & grant_c)) begin
                    accept     = 1'b1;
                    op_a_next  = req_a[grant_id_c];
                    op_b_next  = req_b[grant_id_c];
                    id_next    = grant_id_c;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                result_next = sum_c;
                state_next  = HOLD;
            end
            HOLD: begin
                // Only the owner's ready completes the handshake.
                if (rsp_ready[id]) begin
                    count_next = done_count + CNT_W'(1);
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (state_next == HOLD) begin
            rsp_valid_next = NUM_REQ'(1) << id_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_a       <= '0;
            op_b       <= '0;
            id         <= '0;
            rsp_result <= '0;
            done_count <= '0;
            rsp_valid  <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            op_a       <= op_a_next;
            op_b       <= op_b_next;
            id         <= id_next;
            rsp_result <= result_next;
            done_count <= count_next;
            rsp_valid  <= rsp_valid_next;
            busy       <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_fpu_add_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_fpu_add_scheduler;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        req_valid;
    logic [3:0]        req_ready;
    logic [3:0][31:0]  req_a;
    logic [3:0][31:0]  req_b;
    logic [3:0]        rsp_valid;
    logic [3:0]        rsp_ready;
    logic [31:0]       rsp_result;
    logic              busy;
    logic [3:0]        done_count;

    int checks = 0;
    int errors = 0;
    int ptr_m  = 0;
    int cnt_m  = 0;
    int cyc    = 0;
    int acc_cyc;

    fpu_add_scheduler #(.NUM_REQ(4), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .busy       (busy),
        .done_count (done_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: convert to signed integers, add, re-encode as sign-magnitude with wrapped magnitude.
    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
        longint va, vb, s, m;
        va = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
        vb = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
        s  = va + vb;
        m  = (s < 0) ? -s : s;
        m  = m & 64'h7FFF_FFFF;
        return {(s < 0) && (m != 0), m[30:0]};
    endfunction

    function automatic int model_grant(input logic [3:0] mask);
        for (int k = 0; k < 4; k++) begin
            if (mask[(ptr_m + k) % 4]) return (ptr_m + k) % 4;
        end
        return -1;
    endfunction

    task automatic randomize_ops();
        for (int i = 0; i < 4; i++) begin
            req_a[i] = $urandom;
            if ($urandom_range(0, 7) == 0) req_b[i] = {~req_a[i][31], req_a[i][30:0]};
            else                           req_b[i] = $urandom;
        end
    endtask

    // One full operation from an idle sample point back to the next idle sample point.
    task automatic transact(input logic [3:0] mask, input bit keep, input int hold,
                            input logic [3:0] other, output int g);
        logic [3:0]  oh;
        logic [31:0] exp;
        req_valid = mask;
        #1;
        g   = model_grant(mask);
        oh  = 4'(1 << g);
        exp = model_add(req_a[g], req_b[g]);
        chk("req_ready_idle", req_ready, oh);
        chk("busy_idle", busy, 0);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        ptr_m   = (g + 1) % 4;
        if (!keep) req_valid = 4'b0;
        randomize_ops();
        rsp_ready = other & ~oh;
        #1;
        chk("exec_busy", busy, 1);
        chk("exec_req_ready", req_ready, 0);
        chk("exec_rsp_valid", rsp_valid, 0);
        @(posedge clk);
        #1;
        chk("hold_rsp_valid", rsp_valid, oh);
        chk("hold_result", rsp_result, exp);
        chk("hold_busy", busy, 1);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk("stall_rsp_valid", rsp_valid, oh);
            chk("stall_result", rsp_result, exp);
            chk("stall_req_ready", req_ready, 0);
            chk("stall_busy", busy, 1);
            chk("stall_count", done_count, cnt_m);
        end
        rsp_ready = oh | other;
        @(posedge clk);
        #1;
        cnt_m = (cnt_m + 1) % 16;
        rsp_ready = 4'b0;
        chk("done_rsp_valid", rsp_valid, 0);
        chk("done_busy", busy, 0);
        chk("done_count", done_count, cnt_m);
    endtask

    initial begin
        int g;
        int prev;
        int order [5] = '{0, 1, 2, 3, 0};
        rst_n     = 1'b0;
        req_valid = 4'b0;
        rsp_ready = 4'b0;
        req_a     = '0;
        req_b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", done_count, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_req_ready", req_ready, 0);

        // Contention: all requesters held high, grants rotate every 3 cycles.
        randomize_ops();
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            transact(4'hF, 1'b1, 0, 4'b0, g);
            chk("contention_order", g, order[i]);
            if (i > 0) chk("contention_spacing", acc_cyc - prev, 3);
            prev = acc_cyc;
        end
        req_valid = 4'b0;

        // Single request with known operands: 1.0 + 2.0 = 3.0.
        req_a[0] = 32'h0000_8000;
        req_b[0] = 32'h0001_0000;
        transact(4'b0001, 1'b0, 0, 4'b0, g);
        chk("single_grant", g, 0);
        chk("single_result", rsp_result, 32'h0001_8000);

        // Backpressure on requester 2, then a wrong-ready stall on requester 1.
        transact(4'b0100, 1'b0, 10, 4'b0, g);
        chk("bp_grant", g, 2);
        transact(4'b0010, 1'b0, 3, 4'b1000, g);
        chk("wrong_ready_grant", g, 1);

        // Randomized traffic.
        for (int i = 0; i < 20; i++) begin
            transact(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3), 4'($urandom_range(0, 15)), g);
        end
        req_valid = 4'b0;
        #1;

        // Reset while the operation is in EXEC.
        req_valid = 4'b0100;
        @(posedge clk);
        #1;
        req_valid = 4'b0;
        #2;
        chk("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_result", rsp_result, 0);
        chk("mid_rst_count", done_count, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        @(negedge clk) rst_n = 1'b1;
        ptr_m = 0;
        cnt_m = 0;
        @(posedge clk);
        #1;
        randomize_ops();
        transact(4'hF, 1'b0, 0, 4'b0, g);
        chk("grant_after_reset", g, 0);

        // Counter wrap: 16 completions on a 4-bit counter return it to its start value.
        for (int i = 0; i < 16; i++) begin
            transact(4'($urandom_range(1, 15)), 1'b0, 0, 4'b0, g);
        end
        chk("wrap_count", done_count, 1);
        for (int i = 0; i < 15; i++) begin
            transact(4'($urandom_range(1, 15)), 1'b0, 0, 4'b0, g);
        end
        chk("wrap_to_zero", done_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
